// File: rtl/sigma_pkg.sv
// Shared types, default word format and conversion helpers for the sigma accumulator.
// Helpers work on a fixed MAXW-bit container; callers pass the live width and truncate.
package sigma_pkg;

  localparam int SIGMA_N = 16;
  localparam int SIGMA_F = 8;
  localparam int MAXW    = 64;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} sigma_state_e;

  // Accumulator width that can hold LANES*BEATS full-scale words without overflow.
  function automatic int sigma_w(input int n, input int lanes, input int beats);
    return n + $clog2(lanes * beats);
  endfunction

  // Negative zero maps to 0 because its magnitude is 0.
  function automatic logic signed [MAXW-1:0] sm_to_tc(input logic [MAXW-1:0] word, input int n);
    logic [MAXW-1:0] mag;
    mag = word & ((MAXW'(1) << (n - 1)) - MAXW'(1));
    return word[n-1] ? -signed'(mag) : signed'(mag);
  endfunction

  // Returns {sat, word}; word occupies the low n bits, zero is always +0.
  function automatic logic [MAXW:0] tc_to_sm_sat(input logic signed [MAXW-1:0] value, input int n);
    logic            neg;
    logic            sat;
    logic [MAXW-1:0] mag;
    logic [MAXW-1:0] max_mag;
    logic [MAXW-1:0] sign_bit;
    neg     = value[MAXW-1];
    mag     = unsigned'(neg ? -value : value);
    max_mag = (MAXW'(1) << (n - 1)) - MAXW'(1);
    sat     = (mag > max_mag);
    if (sat) mag = max_mag;
    sign_bit = (neg && (mag != '0)) ? (MAXW'(1) << (n - 1)) : '0;
    return {sat, mag | sign_bit};
  endfunction

endpackage

// File: rtl/sigma_if.sv
// Beat input and frame-result output handshakes of the sigma accumulator.
interface sigma_if
  import sigma_pkg::*;
#(
  parameter int N     = SIGMA_N,
  parameter int LANES = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data [0:LANES-1];
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sigma_tree.sv
// Combinational balanced pairwise adder tree over LANES two's-complement terms.
module sigma_tree #(
  parameter int LANES = 5,
  parameter int W     = 19
) (
  input  logic signed [W-1:0] terms_i [LANES],
  output logic signed [W-1:0] sum_o
);
  localparam int LEVELS = $clog2(LANES);
  localparam int PAD    = 1 << LEVELS;

  logic signed [W-1:0] leaf [PAD];
  logic signed [W-1:0] node [1:2*PAD-1];

  // Pad up to a power of two with zeros so every level pairs cleanly.
  genvar gi;
  generate
    for (gi = 0; gi < PAD; gi++) begin : g_leaf
      if (gi < LANES) begin : g_term
        assign leaf[gi] = terms_i[gi];
      end else begin : g_pad
        assign leaf[gi] = '0;
      end
    end
  endgenerate

  // Heap layout: node[k] = node[2k] + node[2k+1], leaves at PAD..2*PAD-1.
  always_comb begin
    for (int i = 0; i < PAD; i++) node[PAD+i] = leaf[i];
    for (int k = PAD - 1; k >= 1; k--) node[k] = node[2*k] + node[2*k+1];
  end

  assign sum_o = node[1];
endmodule

// File: rtl/sigma_acc.sv
// Streaming signed-magnitude frame accumulator: sums LANES words per beat over up to
// BEATS beats and presents one saturated signed-magnitude total per frame.
module sigma_acc
  import sigma_pkg::*;
#(
  parameter int N     = SIGMA_N,
  parameter int F     = SIGMA_F,
  parameter int LANES = 5,
  parameter int BEATS = 4
) (
  input logic   clk,
  input logic   rst,
  sigma_if.slave bus
);
  localparam int W  = sigma_w(N, LANES, BEATS);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  // F only labels the binary point; it must still leave room for the sign bit.
  generate
    if (W > MAXW || N >= MAXW || F < 0 || F >= N) begin : g_bad_params
      $error("sigma_acc: unsupported N/F/LANES/BEATS combination");
    end
  endgenerate

  sigma_state_e        state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        out_data_q, out_data_d;
  logic                out_sat_q, out_sat_d;

  logic signed [W-1:0] lane_tc [LANES];
  logic signed [W-1:0] beat_sum;
  logic signed [W-1:0] acc_sum;
  logic [MAXW:0]       sm_res;
  logic                unused_hi;
  logic                accept;
  logic                frame_end;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_tc[gi] = W'(sm_to_tc(MAXW'(bus.in_data[gi]), N));
    end
  endgenerate

  sigma_tree #(.LANES(LANES), .W(W)) u_tree (
    .terms_i (lane_tc),
    .sum_o   (beat_sum)
  );

  assign acc_sum   = acc_q + beat_sum;
  assign sm_res    = tc_to_sm_sat(MAXW'(acc_sum), N);
  assign unused_hi = |sm_res[MAXW-1:N];

  assign accept    = bus.in_valid && (state_q == ACC);
  assign frame_end = accept && (bus.in_last || (cnt_q == CW'(BEATS - 1)));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ACC: begin
        if (frame_end) begin
          state_d    = HOLD;
          acc_d      = '0;
          cnt_d      = '0;
          out_data_d = sm_res[N-1:0];
          out_sat_d  = sm_res[MAXW];
        end else if (accept) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // Handshake flags depend on state only, never on the same-cycle inputs.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_sigma_acc.sv
// Self-checking bench for sigma_acc: directed scenarios plus randomized frames
// compared against an integer-arithmetic frame-sum model.
module tb_sigma_acc;
  localparam int N     = 16;
  localparam int F     = 8;
  localparam int LANES = 5;
  localparam int BEATS = 4;

  typedef logic [N-1:0] word_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sigma_if #(.N(N), .LANES(LANES)) bus ();

  sigma_acc #(.N(N), .F(F), .LANES(LANES), .BEATS(BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: signed-magnitude word to plain integer value.
  function automatic longint sm_value(input word_t w);
    longint m;
    m = longint'(w[N-2:0]);
    return w[N-1] ? -m : m;
  endfunction

  function automatic longint beat_value(input word_t w [LANES]);
    longint s = 0;
    for (int i = 0; i < LANES; i++) s += sm_value(w[i]);
    return s;
  endfunction

  function automatic word_t exp_word(input longint s);
    longint maxm;
    longint mag;
    maxm = (longint'(1) <<< (N - 1)) - 1;
    mag  = (s < 0) ? -s : s;
    if (mag > maxm) mag = maxm;
    if (s < 0) return word_t'((longint'(1) <<< (N - 1)) | mag);
    return word_t'(mag);
  endfunction

  function automatic logic exp_sat(input longint s);
    longint maxm;
    maxm = (longint'(1) <<< (N - 1)) - 1;
    return (s > maxm) || (s < -maxm);
  endfunction

  task automatic drive_beat(input word_t w [LANES], input logic last);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0000", bus.out_data); end
    n_checks++;
    if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); end
    $display("reset: in_ready=%b out_valid=%b out_data=%h", bus.in_ready, bus.out_valid, bus.out_data);
  endtask

  task automatic test_full_frame();
    word_t w [LANES];
    foreach (w[i]) w[i] = 16'h0100;
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(w, 1'b0);
      n_checks++;
      if (bus.out_valid !== (b == BEATS - 1)) begin
        n_fail++; $display("FAIL full_valid_beat%0d: got %b want %b", b, bus.out_valid, (b == BEATS - 1));
      end
    end
    n_checks++;
    if (bus.out_data !== 16'h1400) begin n_fail++; $display("FAIL full_data: got %h want 1400", bus.out_data); end
    n_checks++;
    if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL full_sat: got %b want 0", bus.out_sat); end
    $display("full_frame: data=%h sat=%b", bus.out_data, bus.out_sat);
    consume();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_neg_zero();
    word_t w [LANES];
    w[0] = 16'h0100; w[1] = 16'h8100; w[2] = 16'h0080; w[3] = 16'h8080; w[4] = 16'h8000;
    drive_beat(w, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL negzero_valid: got %b want 1", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL negzero_data: got %h want 0000", bus.out_data); end
    n_checks++;
    if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL negzero_sat: got %b want 0", bus.out_sat); end
    $display("neg_zero: data=%h sat=%b", bus.out_data, bus.out_sat);
    consume();
  endtask

  task automatic test_saturation();
    word_t w [LANES];
    word_t vals [2];
    word_t want [2];
    vals[0] = 16'h7FFF; want[0] = 16'h7FFF;
    vals[1] = 16'hFFFF; want[1] = 16'hFFFF;
    for (int t = 0; t < 2; t++) begin
      foreach (w[i]) w[i] = vals[t];
      for (int b = 0; b < BEATS; b++) drive_beat(w, 1'b0);
      n_checks++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat%0d_valid: got %b want 1", t, bus.out_valid); end
      n_checks++;
      if (bus.out_data !== want[t]) begin n_fail++; $display("FAIL sat%0d_data: got %h want %h", t, bus.out_data, want[t]); end
      n_checks++;
      if (bus.out_sat !== 1'b1) begin n_fail++; $display("FAIL sat%0d_flag: got %b want 1", t, bus.out_sat); end
      $display("saturation %h: data=%h sat=%b", vals[t], bus.out_data, bus.out_sat);
      consume();
    end
  endtask

  task automatic test_bubbles();
    word_t w [LANES];
    foreach (w[i]) w[i] = 16'h0100;
    drive_beat(w, 1'b0);
    bus.in_last = 1'b1;
    idle(2);
    bus.in_last = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", bus.out_valid); end
    foreach (w[i]) w[i] = 16'h8080;
    drive_beat(w, 1'b1);
    n_checks++;
    if (bus.out_data !== 16'h0280 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bubble_data: got %h valid %b want 0280 valid 1", bus.out_data, bus.out_valid);
    end
    $display("bubbles: data=%h sat=%b", bus.out_data, bus.out_sat);
    consume();
    foreach (w[i]) w[i] = 16'h0100;
    drive_beat(w, 1'b1);
    n_checks++;
    if (bus.out_data !== 16'h0500) begin n_fail++; $display("FAIL bubble_cleared: got %h want 0500", bus.out_data); end
    $display("after_bubbles: data=%h sat=%b", bus.out_data, bus.out_sat);
    consume();
  endtask

  task automatic test_backpressure();
    word_t w [LANES];
    word_t stuck_d;
    foreach (w[i]) w[i] = 16'h0123;
    drive_beat(w, 1'b1);
    stuck_d = exp_word(beat_value(w));
    foreach (w[i]) w[i] = 16'h0001;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.out_data !== stuck_d || bus.out_sat !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: data=%h sat=%b in_ready=%b out_valid=%b want %h/0/0/1",
                 c, bus.out_data, bus.out_sat, bus.in_ready, bus.out_valid, stuck_d);
      end
      idle(1);
    end
    bus.in_valid = 1'b0;
    $display("backpressure: held data=%h for 10 cycles", bus.out_data);
    consume();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: in_ready=%b want 1", bus.in_ready); end
    foreach (w[i]) w[i] = 16'h8010;
    drive_beat(w, 1'b1);
    n_checks++;
    if (bus.out_data !== 16'h8050) begin n_fail++; $display("FAIL hold_next_frame: got %h want 8050", bus.out_data); end
    $display("post_backpressure: data=%h sat=%b", bus.out_data, bus.out_sat);
    consume();
  endtask

  task automatic test_reset_mid();
    word_t w [LANES];
    foreach (w[i]) w[i] = 16'h0100;
    drive_beat(w, 1'b0);
    drive_beat(w, 1'b0);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    idle(1);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    for (int b = 0; b < BEATS; b++) begin
      drive_beat(w, 1'b0);
      n_checks++;
      if (bus.out_valid !== (b == BEATS - 1)) begin
        n_fail++; $display("FAIL rstmid_valid_beat%0d: got %b want %b", b, bus.out_valid, (b == BEATS - 1));
      end
    end
    n_checks++;
    if (bus.out_data !== 16'h1400) begin n_fail++; $display("FAIL rstmid_data: got %h want 1400", bus.out_data); end
    $display("reset_mid_frame: data=%h sat=%b", bus.out_data, bus.out_sat);
    consume();
  endtask

  task automatic test_random();
    word_t  w [LANES];
    longint sum;
    int     len;
    logic   use_last;
    for (int fr = 0; fr < 40; fr++) begin
      len      = $urandom_range(1, BEATS);
      use_last = (len < BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
      sum      = 0;
      for (int b = 0; b < len; b++) begin
        bus.in_last = 1'($urandom_range(0, 1));
        idle($urandom_range(0, 2));
        for (int i = 0; i < LANES; i++) begin
          case ($urandom_range(0, 2))
            0:       w[i] = word_t'($urandom_range(0, 65535));
            1:       w[i] = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 16'h0FFF))};
            default: w[i] = {1'($urandom_range(0, 1)), 15'($urandom_range(16'h6000, 16'h7FFF))};
          endcase
        end
        sum += beat_value(w);
        drive_beat(w, use_last && (b == len - 1));
        n_checks++;
        if (bus.out_valid !== (b == len - 1)) begin
          n_fail++; $display("FAIL rand%0d_valid_beat%0d: got %b want %b", fr, b, bus.out_valid, (b == len - 1));
        end
      end
      n_checks++;
      if (bus.out_data !== exp_word(sum) || bus.out_sat !== exp_sat(sum)) begin
        n_fail++;
        $display("FAIL rand%0d_result: got %h sat %b want %h sat %b (sum %0d)",
                 fr, bus.out_data, bus.out_sat, exp_word(sum), exp_sat(sum), sum);
      end
      $display("random frame %0d: beats=%0d sum=%0d data=%h sat=%b", fr, len, sum, bus.out_data, bus.out_sat);
      idle($urandom_range(0, 3));
      consume();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    foreach (bus.in_data[i]) bus.in_data[i] = '0;
    test_reset();
    test_full_frame();
    test_neg_zero();
    test_saturation();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit after %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
